// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB responder with wait states, DEPTH x 32-bit register file and sticky protocol error flag
// Word 0 reads a constant ID and is never writable.
module apb_slave_regfile #(
  parameter int          SEL_IDX     = 0,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr,
  output logic        perr,
  input  logic        perr_clr
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  localparam logic [2:0]  WS      = 3'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state, state_next;
  logic [31:0]   regs [DEPTH];
  logic [31:0]   addr_q, wdata_q;
  logic          write_q, err_q;
  logic [2:0]    wcnt;
  logic          sel, err, rdy;
  logic [AW-1:0] idx, idx_q;
  logic          setup_go, write_go, perr_set, wcnt_dec;
  logic          unused_sel_bits;

  assign sel             = Pselx[SEL_IDX];
  assign unused_sel_bits = ^Pselx;
  assign idx             = Paddr[2 +: AW];
  assign idx_q           = addr_q[2 +: AW];
  assign err             = (Paddr[1:0] != 2'b00) || (Paddr[31:2] >= DEPTH_W) ||
                           (Pwrite && (idx == '0));
  assign rdy             = (wcnt == 3'd0);

  always_comb begin
    state_next = state;
    setup_go   = 1'b0;
    write_go   = 1'b0;
    perr_set   = 1'b0;
    wcnt_dec   = 1'b0;
    Pready     = 1'b0;
    Pslverr    = 1'b0;
    case (state)
      IDLE: begin
        if (sel && !Penable) begin
          setup_go   = 1'b1;
          state_next = ACCESS;
        end else if (sel && Penable) begin
          perr_set = 1'b1;
        end
      end
      ACCESS: begin
        Pready  = rdy;
        Pslverr = err_q && rdy;
        // A dropped select or enable aborts the transfer without a write.
        if (!sel || !Penable) begin
          perr_set   = 1'b1;
          state_next = IDLE;
        end else begin
          if ((Paddr != addr_q) || (Pwrite != write_q) || (Pwdata != wdata_q))
            perr_set = 1'b1;
          if (rdy) begin
            write_go   = write_q && !err_q;
            state_next = IDLE;
          end else begin
            wcnt_dec = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wcnt    <= '0;
      Prdata  <= '0;
      perr    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (setup_go) begin
        addr_q  <= Paddr;
        wdata_q <= Pwdata;
        write_q <= Pwrite;
        err_q   <= err;
        wcnt    <= WS;
        if (!Pwrite)
          Prdata <= err ? '0 : ((idx == '0) ? ID_VALUE : regs[idx]);
      end
      if (wcnt_dec) wcnt <= wcnt - 3'd1;
      if (write_go) regs[idx_q] <= wdata_q;
      if (perr_set)      perr <= 1'b1;
      else if (perr_clr) perr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - directed table-driven bench for apb_slave_regfile
// Two slaves share the bus: a on Pselx[0] with no wait states, b on Pselx[1] with three.
module tb_apb_slave_regfile;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic [2:0]  Pselx;
  logic        Penable, Pwrite, perr_clr;
  logic [31:0] Paddr, Pwdata;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b, perr_a, perr_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Hclk = ~Hclk;

  apb_slave_regfile #(.SEL_IDX(0), .DEPTH(16), .WAIT_STATES(0), .ID_VALUE(32'hA9B0_0001)) dut_a (
    .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata_a), .Pready(pready_a),
    .Pslverr(pslverr_a), .perr(perr_a), .perr_clr(perr_clr));

  apb_slave_regfile #(.SEL_IDX(1), .DEPTH(16), .WAIT_STATES(3), .ID_VALUE(32'h1234_5678)) dut_b (
    .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata_b), .Pready(pready_b),
    .Pslverr(pslverr_b), .perr(perr_b), .perr_clr(perr_clr));

  typedef struct {
    int          which;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_waits;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  // One complete SETUP+ACCESS transfer; waits = -1 signals a timeout.
  task automatic xfer(input int which, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output bit slverr, output int waits, output bit other);
    bit done;
    Pselx   = (which == 0) ? 3'b001 : 3'b010;
    Penable = 1'b0;
    Pwrite  = wr;
    Paddr   = addr;
    Pwdata  = wdata;
    step();
    Penable = 1'b1;
    waits = 0; other = 1'b0; slverr = 1'b0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (which == 0) begin
        if (pready_b || pslverr_b) other = 1'b1;
        if (pready_a) begin slverr = pslverr_a; done = 1'b1; end
      end else begin
        if (pready_a || pslverr_a) other = 1'b1;
        if (pready_b) begin slverr = pslverr_b; done = 1'b1; end
      end
      if (!done) waits++;
      step();
    end
    if (!done) waits = -1;
    Pselx   = 3'b000;
    Penable = 1'b0;
    rdata   = (which == 0) ? prdata_a : prdata_b;
  endtask

  initial begin
    logic [31:0] rd;
    bit          se, oth;
    int          wt;
    bit          seen;

    vecs[0]  = '{0, 1'b1, 32'h04, 32'h8500_0000, 32'h0000_0000, 1'b0, 0};
    vecs[1]  = '{0, 1'b0, 32'h04, 32'h0,         32'h8500_0000, 1'b0, 0};
    vecs[2]  = '{0, 1'b0, 32'h00, 32'h0,         32'hA9B0_0001, 1'b0, 0};
    vecs[3]  = '{0, 1'b1, 32'h00, 32'hDEAD_BEEF, 32'hA9B0_0001, 1'b1, 0};
    vecs[4]  = '{0, 1'b0, 32'h00, 32'h0,         32'hA9B0_0001, 1'b0, 0};
    vecs[5]  = '{0, 1'b1, 32'h41, 32'h1111_1111, 32'hA9B0_0001, 1'b1, 0};
    vecs[6]  = '{0, 1'b1, 32'h40, 32'h2222_2222, 32'hA9B0_0001, 1'b1, 0};
    vecs[7]  = '{0, 1'b1, 32'h05, 32'h3333_3333, 32'hA9B0_0001, 1'b1, 0};
    vecs[8]  = '{0, 1'b0, 32'h41, 32'h0,         32'h0000_0000, 1'b1, 0};
    vecs[9]  = '{0, 1'b0, 32'h40, 32'h0,         32'h0000_0000, 1'b1, 0};
    vecs[10] = '{0, 1'b0, 32'h04, 32'h0,         32'h8500_0000, 1'b0, 0};
    vecs[11] = '{0, 1'b1, 32'h3C, 32'h0000_3C3C, 32'h8500_0000, 1'b0, 0};
    vecs[12] = '{0, 1'b0, 32'h3C, 32'h0,         32'h0000_3C3C, 1'b0, 0};
    vecs[13] = '{1, 1'b1, 32'h08, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 3};
    vecs[14] = '{1, 1'b0, 32'h08, 32'h0,         32'hCAFE_F00D, 1'b0, 3};
    vecs[15] = '{1, 1'b0, 32'h00, 32'h0,         32'h1234_5678, 1'b0, 3};
    vecs[16] = '{1, 1'b0, 32'h04, 32'h0,         32'h0000_0000, 1'b0, 3};
    vecs[17] = '{0, 1'b0, 32'h08, 32'h0,         32'h0000_0000, 1'b0, 0};

    Hresetn = 1'b0; Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0;
    Paddr = '0; Pwdata = '0; perr_clr = 1'b0;
    step();
    step();
    chk("reset_pready_a", 32'(pready_a), 32'd0);
    chk("reset_pslverr_a", 32'(pslverr_a), 32'd0);
    chk("reset_prdata_a", prdata_a, 32'h0);
    chk("reset_perr_a", 32'(perr_a), 32'd0);
    chk("reset_pready_b", 32'(pready_b), 32'd0);
    chk("reset_perr_b", 32'(perr_b), 32'd0);
    Hresetn = 1'b1;
    step();

    for (int i = 0; i < 18; i++) begin
      xfer(vecs[i].which, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, se, wt, oth);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_slverr", i), 32'(se), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_waits", i), 32'(wt), 32'(vecs[i].exp_waits));
      chk($sformatf("vec%0d_other_quiet", i), 32'(oth), 32'd0);
    end
    chk("table_perr_a", 32'(perr_a), 32'd0);
    chk("table_perr_b", 32'(perr_b), 32'd0);

    // Penable without SETUP; set wins over a simultaneous clear.
    Pselx = 3'b001; Penable = 1'b1; perr_clr = 1'b1;
    step();
    chk("noset_perr_a", 32'(perr_a), 32'd1);
    chk("noset_perr_b_quiet", 32'(perr_b), 32'd0);
    chk("noset_pready_a", 32'(pready_a), 32'd0);
    Pselx = 3'b000; Penable = 1'b0; perr_clr = 1'b0;
    repeat (3) step();
    chk("perr_sticky", 32'(perr_a), 32'd1);
    perr_clr = 1'b1;
    step();
    perr_clr = 1'b0;
    chk("perr_cleared", 32'(perr_a), 32'd0);

    // Select dropped during ACCESS: abort, no write.
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h0C; Pwdata = 32'h0000_0077;
    step();
    chk("abort_access_pready", 32'(pready_a), 32'd1);
    Pselx = 3'b000; Penable = 1'b1;
    step();
    Penable = 1'b0;
    chk("abort_perr", 32'(perr_a), 32'd1);
    chk("abort_idle_pready", 32'(pready_a), 32'd0);
    xfer(0, 1'b0, 32'h0C, 32'h0, rd, se, wt, oth);
    chk("abort_no_write", rd, 32'h0);
    chk("abort_read_slverr", 32'(se), 32'd0);
    chk("abort_perr_held", 32'(perr_a), 32'd1);

    // Pwdata changes during wait states: perr set, latched data written.
    Pselx = 3'b010; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h10; Pwdata = 32'hAAAA_0001;
    step();
    Penable = 1'b1; Pwdata = 32'hBBBB_0002;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (pready_b) seen = 1'b1;
      step();
    end
    Pselx = 3'b000; Penable = 1'b0;
    chk("chg_completed", 32'(seen), 32'd1);
    chk("chg_perr_b", 32'(perr_b), 32'd1);
    xfer(1, 1'b0, 32'h10, 32'h0, rd, se, wt, oth);
    chk("chg_latched_data", rd, 32'hAAAA_0001);
    chk("chg_read_waits", 32'(wt), 32'd3);

    // Reset during an ACCESS that would otherwise write.
    xfer(0, 1'b0, 32'h3C, 32'h0, rd, se, wt, oth);
    chk("pre_reset_read", rd, 32'h0000_3C3C);
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h04; Pwdata = 32'h5A5A_5A5A;
    step();
    Penable = 1'b1; Hresetn = 1'b0;
    step();
    chk("midreset_pready", 32'(pready_a), 32'd0);
    chk("midreset_prdata", prdata_a, 32'h0);
    chk("midreset_perr_a", 32'(perr_a), 32'd0);
    chk("midreset_perr_b", 32'(perr_b), 32'd0);
    Hresetn = 1'b1; Pselx = 3'b000; Penable = 1'b0;
    step();
    xfer(0, 1'b0, 32'h04, 32'h0, rd, se, wt, oth);
    chk("midreset_no_write", rd, 32'h0);
    xfer(0, 1'b0, 32'h3C, 32'h0, rd, se, wt, oth);
    chk("midreset_regs_cleared", rd, 32'h0);
    xfer(1, 1'b0, 32'h08, 32'h0, rd, se, wt, oth);
    chk("midreset_b_cleared", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
